// File: rtl/shift_pkg.sv
// Purpose: shared mode codes and FSM state encoding for the sequential shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_pkg;

   // Operation select codes (mode input). Code 11 is ROR by default and
   // saturating left shift when SHIFT_SAT_EN is defined.
   localparam logic [1:0] SH_SLL     = 2'b00;
   localparam logic [1:0] SH_SRL     = 2'b01;
   localparam logic [1:0] SH_SRA     = 2'b10;
   localparam logic [1:0] SH_ROR_SAT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Purpose: one combinational shift step of k bit positions in the selected mode.
// Latency: combinational, no registers.
// Backpressure: none; the caller decides when the step result is taken.
//
// Build option: SHIFT_SAT_EN turns mode 11 from rotate-right into saturating
// logical left shift.
// Ports:
//   mode  operation select (SLL/SRL/SRA/ROR-or-SAT)
//   k     positions to shift this step (the caller keeps it within 0..STEP)
//   din   value before the step
//   dout  value after the step
//   ovf   a 1 was pushed out past the MSB by a left shift of k
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] k,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic               ovf
);

   // Left shift done in a double-width vector so the bits that fall off the
   // MSB end are still visible in the upper half.
   logic [2*WIDTH-1:0] sll_ext;
   assign sll_ext = {{WIDTH{1'b0}}, din} << k;
   assign ovf     = |sll_ext[2*WIDTH-1:WIDTH];

`ifndef SHIFT_SAT_EN
   // Rotate: low part shifted right, wrapped part shifted left by WIDTH-k.
   // For k=0 the left shift is by WIDTH and contributes nothing.
   logic [SHAMT_W:0]   k_comp;
   logic [WIDTH-1:0]   ror_val;
   assign k_comp  = (SHAMT_W+1)'(WIDTH) - {1'b0, k};
   assign ror_val = (din >> k) | (din << k_comp);
`endif

   always_comb begin
      dout = sll_ext[WIDTH-1:0];
      case (mode)
         SH_SLL:  dout = sll_ext[WIDTH-1:0];
         SH_SRL:  dout = din >> k;
         SH_SRA:  dout = $unsigned($signed(din) >>> k);
         default: begin
`ifdef SHIFT_SAT_EN
            // Any lost 1 saturates; an all-ones input always loses a 1 for
            // k>0, so saturation persists across later steps by itself.
            dout = ovf ? {WIDTH{1'b1}} : sll_ext[WIDTH-1:0];
`else
            dout = ror_val;
`endif
         end
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// Purpose: multi-cycle shifter (SLL/SRL/SRA/ROR) advancing up to STEP bits per clock.
// Latency: done pulses 1+ceil(shamt/STEP) cycles after an accepted start (1 for shamt=0).
// Backpressure: ready low while RUN; start is ignored then, no request queueing.
//
// Build option: SHIFT_SAT_EN makes mode 11 a saturating left shift and
// enables the sticky sat_flag; otherwise mode 11 rotates right and sat_flag=0.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, mode,      request and its operands; sampled only while ready=1
//   shamt, data_in
//   ready, busy, done handshake status (state != RUN, state == RUN, state == DONE)
//   result            accumulator; final and stable from done to the next start
//   sat_flag          saturation seen during the current operation
module shift_seq_unit
   import shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data_in,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               sat_flag
);

   localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] rem;
   logic [1:0]         mode_q;
   logic [SHAMT_W-1:0] k;
   logic [WIDTH-1:0]   step_out;
   logic               step_ovf;

   // Final step may be shorter than STEP so the total equals shamt exactly.
   assign k = (rem < STEP_AMT) ? rem : STEP_AMT;

   shift_step #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_step (
      .mode (mode_q),
      .k    (k),
      .din  (acc),
      .dout (step_out),
      .ovf  (step_ovf)
   );

   assign ready  = (state != ST_RUN);
   assign busy   = (state == ST_RUN);
   assign done   = (state == ST_DONE);
   assign result = acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         acc    <= '0;
         rem    <= '0;
         mode_q <= SH_SLL;
      end else begin
         case (state)
            ST_RUN: begin
               acc <= step_out;
               rem <= rem - k;
               if (rem == k) state <= ST_DONE;
            end
            // IDLE and DONE both accept a request; DONE falls back to IDLE
            // after one cycle unless a back-to-back start arrives.
            default: begin
               if (start) begin
                  acc    <= data_in;
                  rem    <= shamt;
                  mode_q <= mode;
                  state  <= (shamt == '0) ? ST_DONE : ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef SHIFT_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sat_flag <= 1'b0;
      end else if (ready && start) begin
         sat_flag <= 1'b0;
      end else if (busy && (mode_q == SH_ROR_SAT) && step_ovf) begin
         sat_flag <= 1'b1;
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = step_ovf;
   assign sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// Purpose: scoreboard bench for shift_seq_unit, three instances with STEP = 1, 2, 4.
// Latency: checks done timing against 1+ceil(shamt/STEP) from the start cycle.
// Backpressure: requests are issued only when every instance reports ready.
module tb_shift_seq_unit;
   import shift_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic        sat;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mode;
   logic [4:0]  shamt;
   logic [31:0] data_in;

   logic [2:0]  ready_v, busy_v, done_v, sat_v;
   logic [31:0] res_v [3];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   exp_t q0[$], q1[$], q2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int ST = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      shift_seq_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(ST)) u_dut (
         .clk      (clk),
         .reset    (reset),
         .start    (start),
         .mode     (mode),
         .shamt    (shamt),
         .data_in  (data_in),
         .ready    (ready_v[g]),
         .busy     (busy_v[g]),
         .done     (done_v[g]),
         .result   (res_v[g]),
         .sat_flag (sat_v[g])
      );
   end

   function automatic int step_of(int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
   endfunction

   // Single-shot reference: the whole shift applied at once.
   function automatic logic [32:0] ref_op(logic [1:0] m, logic [4:0] s, logic [31:0] d);
      logic [63:0] wide;
      logic [31:0] r;
      logic        sat;
      sat  = 1'b0;
      wide = {32'b0, d} << s;
      case (m)
         2'b00: r = d << s;
         2'b01: r = d >> s;
         2'b10: r = (d >> s) | (d[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
         default: begin
`ifdef SHIFT_SAT_EN
            if (wide[63:32] != 32'h0) begin
               r   = 32'hFFFF_FFFF;
               sat = 1'b1;
            end else begin
               r = wide[31:0];
            end
`else
            wide = {d, d} >> s;
            r    = wide[31:0];
`endif
         end
      endcase
      return {sat, r};
   endfunction

   task automatic push_exp(input int c0, input logic [4:0] s, input logic [31:0] r, input logic sat);
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.res = r;
         e.sat = sat;
         e.cyc = c0 + ((s == 0) ? 1 : 1 + (int'(s) + step_of(i) - 1) / step_of(i));
         case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic check_done(input int i);
      exp_t e;
      logic got;
      got = 1'b0;
      case (i)
         0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
         1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
      endcase
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL unexpected_done step=%0d cycle=%0d result=%h", step_of(i), cyc, res_v[i]);
      end else begin
         checks++;
         if (res_v[i] !== e.res) begin
            errors++;
            $display("FAIL result step=%0d cycle=%0d got=%h want=%h", step_of(i), cyc, res_v[i], e.res);
         end
         checks++;
         if (sat_v[i] !== e.sat) begin
            errors++;
            $display("FAIL sat_flag step=%0d cycle=%0d got=%b want=%b", step_of(i), cyc, sat_v[i], e.sat);
         end
         checks++;
         if (cyc != e.cyc) begin
            errors++;
            $display("FAIL done_cycle step=%0d got=%0d want=%0d", step_of(i), cyc, e.cyc);
         end
      end
   endtask

   // Monitor: samples on the falling edge, independent of the stimulus.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int i = 0; i < 3; i++) begin
            if (done_v[i] === 1'b1) check_done(i);
         end
      end
   end

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (ready_v !== 3'b111) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > 500) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=%b want=111", ready_v);
            break;
         end
      end
   endtask

   // Issues one request with an explicit expected outcome. With hold=1 start
   // stays high (with junk operands) through RUN and is left high on return,
   // so the next call lands in the DONE cycle as a back-to-back request.
   task automatic issue(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d,
                        input logic [31:0] r, input logic sat, input logic hold, output int c0);
      int guard;
      wait_ready();
      start   = 1'b1;
      mode    = m;
      shamt   = s;
      data_in = d;
      c0      = cyc;
      push_exp(c0, s, r, sat);
      @(posedge clk);
      #1;
      if (!hold) begin
         start = 1'b0;
      end else begin
         guard = 0;
         while (ready_v !== 3'b111 && guard < 100) begin
            mode    = 2'($urandom);
            shamt   = 5'($urandom);
            data_in = $urandom;
            @(posedge clk);
            #1;
            guard++;
         end
      end
   endtask

   task automatic issue_model(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
      logic [32:0] x;
      int c0;
      x = ref_op(m, s, d);
      issue(m, s, d, x[31:0], x[32], 1'b0, c0);
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({res_v[i], done_v[i], ready_v[i], busy_v[i], sat_v[i]} !== {32'h0, 4'b0100}) begin
            errors++;
            $display("FAIL %s step=%0d got res=%h done=%b ready=%b busy=%b sat=%b want res=0 done=0 ready=1 busy=0 sat=0",
                     tag, step_of(i), res_v[i], done_v[i], ready_v[i], busy_v[i], sat_v[i]);
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checks++;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want=0", q0.size() + q1.size() + q2.size());
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d want completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c0;
      logic [1:0]  m;
      logic [4:0]  s;
      logic [31:0] d;

      start   = 1'b0;
      mode    = 2'b00;
      shamt   = 5'd0;
      data_in = 32'h0;
      reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_idle_outputs("reset_state");

      // Directed cases with hand-derived results.
      issue(SH_SRA, 5'd4,  32'h8000_0010, 32'hF800_0001, 1'b0, 1'b0, c0);
      issue(SH_SLL, 5'd7,  32'h0000_000F, 32'h0000_0780, 1'b0, 1'b0, c0);
`ifdef SHIFT_SAT_EN
      issue(SH_ROR_SAT, 5'd31, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, c0);
`else
      issue(SH_ROR_SAT, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, c0);
`endif
      issue(SH_SRL, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, c0);
      // Start held through RUN, then a back-to-back request in DONE.
      issue(SH_SLL, 5'd1,  32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, c0);
      issue(SH_SRL, 5'd1,  32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, c0);
`ifdef SHIFT_SAT_EN
      issue(SH_ROR_SAT, 5'd2, 32'h4000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, c0);
      issue(SH_ROR_SAT, 5'd3, 32'h0000_0001, 32'h0000_0008, 1'b0, 1'b0, c0);
`else
      issue(SH_ROR_SAT, 5'd2, 32'h4000_0000, 32'h1000_0000, 1'b0, 1'b0, c0);
      issue(SH_ROR_SAT, 5'd3, 32'h0000_0001, 32'h2000_0000, 1'b0, 1'b0, c0);
`endif
      drain();

      // Randomized requests against the single-shot model.
      for (int n = 0; n < 80; n++) begin
         m = 2'($urandom);
         s = 5'($urandom);
         d = $urandom;
         case ($urandom_range(0, 7))
            0: d = 32'h8000_0000;
            1: d = 32'hFFFF_FFFF;
            2: s = 5'd31;
            3: s = 5'd0;
            default: ;
         endcase
         issue_model(m, s, d);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      drain();

      // Abort mid-RUN: no done may follow for the aborted request.
      issue(SH_SLL, 5'd20, 32'h0000_0001, 32'h0010_0000, 1'b0, 1'b0, c0);
      while (cyc < c0 + 5) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (busy_v !== 3'b111) begin
         errors++;
         $display("FAIL busy_mid_run got=%b want=111", busy_v);
      end
      reset = 1'b1;
      #1;
      check_idle_outputs("reset_abort");
      q0.delete();
      q1.delete();
      q2.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
      end
      issue(SH_SRA, 5'd3, 32'h8000_0000, 32'hF000_0000, 1'b0, 1'b0, c0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Parametrised, multi-cycle shift engine for the DLX datapath and image-sharpening extension.
- Supports logical left, logical right, arithmetic right and rotate right.
- Shift amount is variable, applied at STEP bit positions per clock, under a start/done handshake.
- Sits beside the ALU in EX. The pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, data width in bits (power of two, ≥4).
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 1, maximum bit positions shifted per cycle (1, 2, 4 or 8; STEP < WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when ready=1
- mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (SAT under SHIFT_SAT_EN)
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1
- data_in  in  WIDTH  operand
- ready  out  1  high when a start will be accepted
- busy  out  1  high while shifting (state RUN)
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  shifted value, held until the next accepted start
- sat_flag  out  1  saturation occurred (always 0 without SHIFT_SAT_EN)

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE; acc=0; rem=0; mode_q=00
  - result=0, done=0, busy=0, ready=1, sat_flag=0
- States: IDLE, RUN, DONE.
- ready = (state != RUN); busy = (state == RUN); done = (state == DONE); result = acc.
- Start acceptance (in IDLE or DONE, start=1):
  - latch acc<=data_in, rem<=shamt, mode_q<=mode; clear sat_flag
  - go to DONE if shamt==0, else RUN
- RUN, each cycle:
  - k = min(STEP, rem); acc <= step(acc, k, mode_q); rem <= rem-k
  - go to DONE when rem-k==0
- DONE lasts exactly one cycle, then IDLE unless a new start is accepted in that cycle (back-to-back allowed).
- Latency: with start high in cycle 0, done is high in cycle 1+ceil(shamt/STEP). shamt=0 gives latency 1 and result=data_in.
- start while RUN is ignored. No queueing; inputs are don't-care once latched.
- Step semantics over k bits:
  - SLL: zero-fill LSBs
  - SRL: zero-fill MSBs
  - SRA: replicate MSB of acc
  - ROR: bits leaving the LSB re-enter at the MSB
- Final value must equal the single-shot shift by shamt for every mode.
- result stays stable from done until the next accepted start. Outside DONE it may be read but is not guaranteed final.
- Reset mid-RUN aborts the operation: outputs return to reset values, and no done is issued for the aborted request.
- shamt is SHAMT_W bits wide, so amounts ≥WIDTH are unrepresentable. No out-of-range handling is needed.

Optional Feature:
- Macro: SHIFT_SAT_EN.
- Defined: mode 11 = saturating logical left (SAT).
  - Each step, if any of the k bits shifted out of the MSB end is 1, acc becomes all-ones and sat_flag sets sticky.
  - Once saturated, further steps leave acc all-ones.
  - sat_flag clears on the next accepted start.
- Undefined: mode 11 = ROR; sat_flag is constant 0.

Decomposition:
- Package shift_pkg:
  - mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR_SAT=2'b11
  - state encoding ST_IDLE, ST_RUN, ST_DONE
- One combinational sub-module, shift_step: shifts a WIDTH-bit value by k (0..STEP) per mode, and outputs the shifted-out-nonzero indication used for SAT.
- The FSM, counters and registers stay in shift_seq_unit.

Test Plan:
- Reset/idle: reset high for 3 cycles, then low. Expect result=0, done=0, ready=1, busy=0. Assert reset mid-RUN (STEP=1, shamt=20, at cycle 5): outputs go to 0 immediately and no done pulse follows.
- SRA latency: STEP=1, SRA, data_in=0x80000010, shamt=4. Expect busy in cycles 1-4, done in cycle 5, result=0xF8000001.
- Multi-step partial: STEP=4, SLL, data_in=0x0000000F, shamt=7. Expect done in cycle 3 (steps of 4 then 3), result=0x00000780.
- Rotate and zero shift: STEP=2, ROR, data_in=0x00000001, shamt=31 gives result=0x00000002 at cycle 17. shamt=0, SRL, data_in=0xDEADBEEF gives done in cycle 1, result=0xDEADBEEF.
- Handshake: start held high during RUN is ignored. A new start in the DONE cycle is accepted, producing consecutive results 0x00000002 (SLL 1 of 0x1) then 0x00000001 (SRL 1 of 0x2), with done in cycles 2 and 4.
- SHIFT_SAT_EN: mode 11, data_in=0x40000000, shamt=2, STEP=1 gives result=0xFFFFFFFF and sat_flag=1. Next start with data_in=0x1, shamt=3 gives result=0x8 and sat_flag=0. Without the macro, the same first stimulus gives result=0x10000000 and sat_flag=0.
